// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command sequencer driving an up/down counter's load/ce/dir pins.
// Optional boundary saturation is enabled by defining CNT_SEQ_SAT_EN.
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_data,
    output logic              load_n,
    output logic              ce,
    output logic              up_down,
    output logic [WIDTH-1:0]  data_load,
    input  logic              max_count,
    input  logic              zero,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    state_t             state_q;
    logic [STEP_W-1:0]  rem_q;
    logic               load_n_q;
    logic               ce_q;
    logic               up_down_q;
    logic [WIDTH-1:0]   data_load_q;
    logic               done_q;
    logic               sat_q;
    logic               accept;
    logic               stop;

    assign accept = cmd_valid & cmd_ready;

`ifdef CNT_SEQ_SAT_EN
    // Gate ce in the same cycle the counter reports the boundary so it never wraps.
    assign stop = (state_q == S_RUN) & ((up_down_q & max_count) | (~up_down_q & zero));
`else
    logic unused_flags;
    assign unused_flags = &{1'b0, max_count, zero};
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            load_n_q    <= 1'b1;
            ce_q        <= 1'b0;
            up_down_q   <= 1'b1;
            data_load_q <= '0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                state_q     <= S_LOAD;
                                load_n_q    <= 1'b0;
                                data_load_q <= cmd_data[WIDTH-1:0];
                            end
                            OP_UP, OP_DOWN: begin
                                if (cmd_data == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q   <= S_RUN;
                                    ce_q      <= 1'b1;
                                    up_down_q <= ~cmd_op[0];
                                    rem_q     <= cmd_data;
                                end
                            end
                            default: begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    load_n_q <= 1'b1;
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                end
                S_RUN: begin
                    if (stop) begin
                        ce_q    <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        sat_q   <= 1'b1;
                    end else begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == STEP_W'(1)) begin
                            ce_q    <= 1'b0;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign load_n    = load_n_q;
    assign ce        = ce_q & ~stop;
    assign up_down   = up_down_q;
    assign data_load = data_load_q;
    assign done      = done_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer with an attached counter model.
module tb_counter_sequencer;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [STEP_W-1:0] cmd_data = '0;
    logic              load_n, ce, up_down;
    logic [WIDTH-1:0]  data_load;
    logic              max_count, zero;
    logic              busy, done, sat;
    logic [WIDTH-1:0]  count_out;

    counter_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .load_n(load_n), .ce(ce),
        .up_down(up_down), .data_load(data_load), .max_count(max_count),
        .zero(zero), .busy(busy), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       count_out <= '0;
        else if (!load_n) count_out <= data_load;
        else if (ce)      count_out <= up_down ? count_out + 1'b1 : count_out - 1'b1;
    end
    assign max_count = (count_out == '1);
    assign zero      = (count_out == '0);

    typedef struct {
        int idx;
        int sat;
        int cnt;
        int busy;
        int ce;
        int ld;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cmd_idx = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic expect_cmd(input int s, input int c, input int b, input int e, input int l);
        exp_t x;
        x.idx = cmd_idx; x.sat = s; x.cnt = c; x.busy = b; x.ce = e; x.ld = l;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("cmd%0d_ready_wait", cmd_idx), int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_idx++;
    endtask

    // Monitor: accumulate per-command activity and compare against the scoreboard on done.
    int busy_cnt = 0, ce_cnt = 0, ld_cnt = 0, overlap_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0; ce_cnt = 0; ld_cnt = 0; overlap_cnt = 0;
        end else begin
            if (busy)        busy_cnt++;
            if (ce)          ce_cnt++;
            if (!load_n)     ld_cnt++;
            if (!load_n && ce) overlap_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk($sformatf("cmd%0d_sat", x.idx),     int'(sat),       x.sat);
                    chk($sformatf("cmd%0d_count", x.idx),   int'(count_out), x.cnt);
                    chk($sformatf("cmd%0d_busy", x.idx),    busy_cnt,        x.busy);
                    chk($sformatf("cmd%0d_ce", x.idx),      ce_cnt,          x.ce);
                    chk($sformatf("cmd%0d_load", x.idx),    ld_cnt,          x.ld);
                    chk($sformatf("cmd%0d_overlap", x.idx), overlap_cnt,     0);
                end
                busy_cnt = 0; ce_cnt = 0; ld_cnt = 0; overlap_cnt = 0;
            end
        end
    end

    localparam logic [1:0] NOP = 2'b00, LD = 2'b01, UP = 2'b10, DN = 2'b11;

    initial begin
        int k;
        int n;
        #13;
        chk("rst_load_n",    int'(load_n),    1);
        chk("rst_ce",        int'(ce),        0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_done",      int'(done),      0);
        chk("rst_sat",       int'(sat),       0);
        chk("rst_up_down",   int'(up_down),   1);
        chk("rst_data_load", int'(data_load), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        expect_cmd(0, 9, 2, 0, 1);   send(LD, 8'h09);
        expect_cmd(0, 14, 6, 5, 0);  send(UP, 8'd5);
        expect_cmd(0, 1, 2, 0, 1);   send(LD, 8'h01);
`ifdef CNT_SEQ_SAT_EN
        expect_cmd(1, 0, 3, 1, 0);   send(DN, 8'd3);
        expect_cmd(0, 0, 1, 0, 0);   send(UP, 8'd0);
        expect_cmd(0, 0, 1, 0, 0);   send(NOP, 8'd7);
`else
        expect_cmd(0, 14, 4, 3, 0);  send(DN, 8'd3);
        expect_cmd(0, 14, 1, 0, 0);  send(UP, 8'd0);
        expect_cmd(0, 14, 1, 0, 0);  send(NOP, 8'd7);
`endif
        expect_cmd(0, 14, 2, 0, 1);  send(LD, 8'hFE);
`ifdef CNT_SEQ_SAT_EN
        expect_cmd(1, 15, 3, 1, 0);  send(UP, 8'd3);
`else
        expect_cmd(0, 1, 4, 3, 0);   send(UP, 8'd3);
`endif
        expect_cmd(0, 1, 2, 0, 1);   send(LD, 8'h01);
`ifdef CNT_SEQ_SAT_EN
        expect_cmd(1, 15, 16, 14, 0); send(UP, 8'd20);
`else
        expect_cmd(0, 5, 21, 20, 0);  send(UP, 8'd20);
`endif
        expect_cmd(0, 0, 2, 0, 1);   send(LD, 8'h00);

        // UP 10 aborted by reset after four steps: no scoreboard entry, so any done is flagged.
        send(UP, 8'd10);
        k = 0;
        n = 0;
        while (k < 4 && n < 50) begin
            if (ce) k++;
            if (k < 4) @(negedge clk);
            n++;
        end
        chk("abort_steps_seen", k, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ce",      int'(ce),        0);
        chk("abort_load_n",  int'(load_n),    1);
        chk("abort_busy",    int'(busy),      0);
        chk("abort_done",    int'(done),      0);
        chk("abort_count",   int'(count_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", int'(cmd_ready), 1);

        expect_cmd(0, 5, 2, 0, 1);   send(LD, 8'h05);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
